regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (wr_en / wr_reg_add / wr_data) between two writeback sources: A (ALU result) and M (memory load data).
- Each source gets a small FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFO heads into a registered write port.
- A pending-write scoreboard lets decode stall reads whose source register still has a write in flight.

---
 rtl/regfile_wb_arbiter_if.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources, the register file write port
// and the decode-stage scoreboard query.
interface regfile_wb_arbiter_if #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 16
);
   logic          a_valid;
   logic          a_ready;
   logic [AW-1:0] a_add;
   logic [DW-1:0] a_data;
   logic          m_valid;
   logic          m_ready;
   logic [AW-1:0] m_add;
   logic [DW-1:0] m_data;
   logic          wr_en;
   logic [AW-1:0] wr_reg_add;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] q_add_1;
   logic [AW-1:0] q_add_2;
   logic          q_busy_1;
   logic          q_busy_2;

   // Arbiter side
   modport slave (
      input  a_valid, a_add, a_data, m_valid, m_add, m_data, q_add_1, q_add_2,
      output a_ready, m_ready, wr_en, wr_reg_add, wr_data, q_busy_1, q_busy_2
   );

   // Sources / register file / decode side
   modport master (
      output a_valid, a_add, a_data, m_valid, m_add, m_data, q_add_1, q_add_2,
      input  a_ready, m_ready, wr_en, wr_reg_add, wr_data, q_busy_1, q_busy_2
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register file write port between ALU (A) and memory (M)
// writeback sources: one small FIFO per source, round-robin drain into a
// registered write port, plus a pending-write scoreboard for decode.
module regfile_wb_arbiter #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 4,
   parameter int unsigned DW    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   regfile_wb_arbiter_if.slave   bus
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned NS = 2;   // source 0 = A, source 1 = M

   typedef struct packed {
      logic [AW-1:0] add;
      logic [DW-1:0] data;
   } wb_entry_t;

   wb_entry_t     mem      [NS][DEPTH];
   wb_entry_t     in_entry [NS];
   logic [PW-1:0] rd_ptr   [NS];
   logic [PW-1:0] wr_ptr   [NS];
   logic [CW-1:0] count    [NS];

   logic [NS-1:0] in_valid;
   logic [NS-1:0] ready;
   logic [NS-1:0] not_empty;
   logic [NS-1:0] push;
   logic [NS-1:0] pop;

   logic          last_grant_m;
   logic          grant_valid;
   logic          grant_m;
   wb_entry_t     head;

   logic          wr_en_q;
   logic [AW-1:0] wr_add_q;
   logic [DW-1:0] wr_data_q;
   logic          busy_1;
   logic          busy_2;

   assign in_valid    = {bus.m_valid, bus.a_valid};
   assign in_entry[0] = '{add: bus.a_add, data: bus.a_data};
   assign in_entry[1] = '{add: bus.m_add, data: bus.m_data};

   // FIFO status and push qualification; ready depends on occupancy only
   always_comb begin
      ready     = '0;
      not_empty = '0;
      push      = '0;
      for (int s = 0; s < NS; s++) begin
         ready[s]     = (count[s] != CW'(DEPTH));
         not_empty[s] = (count[s] != '0);
         push[s]      = in_valid[s] & ready[s] & ~flush;
      end
   end

   // Round-robin grant on FIFO heads; on a tie the source not granted last wins
   always_comb begin
      grant_valid = |not_empty;
      grant_m     = not_empty[1] & (~not_empty[0] | ~last_grant_m);
      pop         = '0;
      if (!flush) begin
         pop[0] = grant_valid & ~grant_m;
         pop[1] = grant_m;
      end
      head = grant_m ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];
   end

   // FIFO pointers and occupancy; flush empties both FIFOs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NS; s++) begin
            rd_ptr[s] <= '0;
            wr_ptr[s] <= '0;
            count[s]  <= '0;
         end
      end else if (flush) begin
         for (int s = 0; s < NS; s++) begin
            rd_ptr[s] <= '0;
            wr_ptr[s] <= '0;
            count[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < NS; s++) begin
            if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
            if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
            count[s] <= count[s] + CW'(push[s]) - CW'(pop[s]);
         end
      end
   end

   // FIFO storage; payload captured at the push edge
   always_ff @(posedge clk) begin
      for (int s = 0; s < NS; s++) begin
         if (push[s]) mem[s][wr_ptr[s]] <= in_entry[s];
      end
   end

   // Registered write port and round-robin history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q      <= 1'b0;
         wr_add_q     <= '0;
         wr_data_q    <= '0;
         last_grant_m <= 1'b1;
      end else if (flush) begin
         wr_en_q <= 1'b0;
      end else begin
         wr_en_q <= grant_valid;
         if (grant_valid) begin
            wr_add_q     <= head.add;
            wr_data_q    <= head.data;
            last_grant_m <= grant_m;
         end
      end
   end

   // Scoreboard: any stored entry or the write on the port targets the query
   always_comb begin
      busy_1 = wr_en_q && (wr_add_q == bus.q_add_1);
      busy_2 = wr_en_q && (wr_add_q == bus.q_add_2);
      for (int s = 0; s < NS; s++) begin
         for (int k = 0; k < DEPTH; k++) begin
            logic [PW-1:0] idx;
            idx = rd_ptr[s] + PW'(k);
            if (CW'(k) < count[s]) begin
               if (mem[s][idx].add == bus.q_add_1) busy_1 = 1'b1;
               if (mem[s][idx].add == bus.q_add_2) busy_2 = 1'b1;
            end
         end
      end
   end

   assign bus.a_ready    = ready[0];
   assign bus.m_ready    = ready[1];
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_reg_add = wr_add_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.q_busy_1   = busy_1;
   assign bus.q_busy_2   = busy_2;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;
   logic clk;
   logic rst;
   logic flush;
   int   n_tests;
   int   n_fail;

   regfile_wb_arbiter_if #(.AW(4), .DW(16)) bus ();

   regfile_wb_arbiter #(.DEPTH(2), .AW(4), .DW(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                        input logic mv, input logic [3:0] ma, input logic [15:0] md);
      bus.a_valid = av;
      bus.a_add   = aa;
      bus.a_data  = ad;
      bus.m_valid = mv;
      bus.m_add   = ma;
      bus.m_data  = md;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  log_add  [64];
      logic [15:0] log_data [64];
      int          n_log;
      int          a_idx;
      int          m_idx;
      int          ai;
      int          mi;
      logic        a_push;
      logic        m_push;
      logic        seen_a_full;

      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      flush   = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      bus.q_add_1 = 4'd0;
      bus.q_add_2 = 4'd5;

      // Reset state
      #100;
      rst = 1'b0;
      #1;
      check("rst_wr_en",   32'(bus.wr_en),    32'd0);
      check("rst_a_ready", 32'(bus.a_ready),  32'd1);
      check("rst_m_ready", 32'(bus.m_ready),  32'd1);
      check("rst_busy1",   32'(bus.q_busy_1), 32'd0);
      check("rst_busy2",   32'(bus.q_busy_2), 32'd0);
      tick();

      // Tie: A wins after reset, and again on repeat since M was granted last
      for (int r = 0; r < 2; r++) begin
         drive(1'b1, 4'd7, 16'h0542, 1'b1, 4'd10, 16'h1F5B);
         tick();
         drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
         check("tie_idle",     32'(bus.wr_en),      32'd0);
         tick();
         check("tie_a_en",     32'(bus.wr_en),      32'd1);
         check("tie_a_add",    32'(bus.wr_reg_add), 32'd7);
         check("tie_a_data",   32'(bus.wr_data),    32'h0542);
         tick();
         check("tie_m_en",     32'(bus.wr_en),      32'd1);
         check("tie_m_add",    32'(bus.wr_reg_add), 32'd10);
         check("tie_m_data",   32'(bus.wr_data),    32'h1F5B);
         tick();
         check("tie_done_en",  32'(bus.wr_en),      32'd0);
         check("tie_hold_add", 32'(bus.wr_reg_add), 32'd10);
      end

      // Single write from A to R5
      check("single_pre_busy", 32'(bus.q_busy_2), 32'd0);
      drive(1'b1, 4'd5, 16'h04F2, 1'b0, 4'd0, 16'h0);
      tick();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      check("single_busy_q",  32'(bus.q_busy_2),   32'd1);
      check("single_en_lat",  32'(bus.wr_en),      32'd0);
      tick();
      check("single_en",      32'(bus.wr_en),      32'd1);
      check("single_add",     32'(bus.wr_reg_add), 32'd5);
      check("single_data",    32'(bus.wr_data),    32'h04F2);
      check("single_busy_wr", 32'(bus.q_busy_2),   32'd1);
      tick();
      check("single_en_off",  32'(bus.wr_en),      32'd0);
      check("single_busy_off",32'(bus.q_busy_2),   32'd0);
      check("single_hold",    32'(bus.wr_data),    32'h04F2);

      // Backpressure: A pushes R1..R5 while M streams; last grant is A here
      a_idx       = 1;
      m_idx       = 0;
      n_log       = 0;
      seen_a_full = 1'b0;
      for (int c = 0; c < 14; c++) begin
         drive(a_idx <= 5, 4'(a_idx), 16'hB200 + 16'(a_idx),
               1'b1, 4'(8 + (m_idx % 8)), 16'hC000 + 16'(m_idx));
         if (!bus.a_ready) seen_a_full = 1'b1;
         a_push = bus.a_valid & bus.a_ready;
         m_push = bus.m_ready;
         tick();
         if (a_push) a_idx++;
         if (m_push) m_idx++;
         if (bus.wr_en) begin
            log_add[n_log]  = bus.wr_reg_add;
            log_data[n_log] = bus.wr_data;
            n_log++;
         end
      end
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus.wr_en) begin
            log_add[n_log]  = bus.wr_reg_add;
            log_data[n_log] = bus.wr_data;
            n_log++;
         end
      end
      check("bp_a_full_seen", 32'(seen_a_full), 32'd1);
      // Expected order: M0, A1, M1, A2, M2, A3, M3, A4, M4, A5
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0)
            check("bp_alt_m", 32'(log_add[k]), 32'(8 + (k / 2)));
         else
            check("bp_alt_a", 32'(log_add[k]), 32'((k + 1) / 2));
      end
      ai = 1;
      mi = 0;
      for (int k = 0; k < n_log; k++) begin
         if (log_add[k] < 4'd8) begin
            check("bp_a_add",  32'(log_add[k]),  32'(ai));
            check("bp_a_data", 32'(log_data[k]), 32'(16'hB200 + 16'(ai)));
            ai++;
         end else begin
            check("bp_m_data", 32'(log_data[k]), 32'(16'hC000 + 16'(mi)));
            mi++;
         end
      end
      check("bp_a_count", 32'(ai - 1), 32'd5);
      check("bp_m_count", 32'(mi),     32'(m_idx));

      // Flush while a write is on the port
      bus.q_add_1 = 4'd12;
      bus.q_add_2 = 4'd3;
      drive(1'b1, 4'd2, 16'h2222, 1'b1, 4'd12, 16'hCCCC);
      tick();
      drive(1'b1, 4'd3, 16'h3333, 1'b1, 4'd13, 16'hDDDD);
      tick();
      check("fl_pre_en",    32'(bus.wr_en),      32'd1);
      check("fl_pre_add",   32'(bus.wr_reg_add), 32'd2);
      check("fl_pre_busy1", 32'(bus.q_busy_1),   32'd1);
      check("fl_pre_busy2", 32'(bus.q_busy_2),   32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      check("fl_en",      32'(bus.wr_en),    32'd0);
      check("fl_a_ready", 32'(bus.a_ready),  32'd1);
      check("fl_m_ready", 32'(bus.m_ready),  32'd1);
      check("fl_busy1",   32'(bus.q_busy_1), 32'd0);
      check("fl_busy2",   32'(bus.q_busy_2), 32'd0);
      tick();
      check("fl_no_push", 32'(bus.wr_en),    32'd0);

      // Flush keeps last_grant (A), so M wins the next tie
      drive(1'b1, 4'd4, 16'h4444, 1'b1, 4'd14, 16'hEEEE);
      tick();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      check("lg_first",  32'(bus.wr_reg_add), 32'd14);
      check("lg_first_d",32'(bus.wr_data),    32'hEEEE);
      tick();
      check("lg_second", 32'(bus.wr_reg_add), 32'd4);
      tick();
      check("lg_idle",   32'(bus.wr_en),      32'd0);

      // Asynchronous reset between edges with entries pending
      bus.q_add_1 = 4'd6;
      bus.q_add_2 = 4'd11;
      drive(1'b1, 4'd6, 16'h6666, 1'b1, 4'd11, 16'hBBBB);
      tick();
      tick();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      check("ar_pre_en",    32'(bus.wr_en),      32'd1);
      check("ar_pre_add",   32'(bus.wr_reg_add), 32'd11);
      check("ar_pre_busy1", 32'(bus.q_busy_1),   32'd1);
      #3;
      rst = 1'b1;
      #1;
      check("ar_en",      32'(bus.wr_en),      32'd0);
      check("ar_add",     32'(bus.wr_reg_add), 32'd0);
      check("ar_a_ready", 32'(bus.a_ready),    32'd1);
      check("ar_m_ready", 32'(bus.m_ready),    32'd1);
      check("ar_busy1",   32'(bus.q_busy_1),   32'd0);
      check("ar_busy2",   32'(bus.q_busy_2),   32'd0);
      #2;
      rst = 1'b0;
      tick();
      check("ar_post_en", 32'(bus.wr_en),      32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
